fpu_sequencer: RTL and testbench
================================

Name: fpu_sequencer

Overview:
Multi-cycle control sequencer for the floating point unit datapath. It accepts one operation request at a time over a valid/ready handshake and steps the datapath through unpack, align, arithmetic, normalize and pack stages. It waits on status flags from the datapath and returns completion over a second valid/ready handshake. It carries no operand data; it drives stage selects and enables only.

Parameters:
bitness, 64, datapath width (operand ports are [bitness:0]); sets loop limits
command_size, 2, command port is [command_size:0]
mul_cycles, 4, OP-stage cycles for mul (>=1)
div_cycles, 53, OP-stage cycles for div (>=1)
mant_bits, 53, mantissa width; align/normalize loop limit = mant_bits+2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer idle and able to accept
req_command  in  command_size+1  0=sum, 1=sub, 2=mul, 3=div, others illegal
align_done  in  1  datapath: exponents equal
norm_done  in  1  datapath: mantissa normalized or zero
stage  out  4  current stage code
stage_en  out  1  datapath performs the stage step this cycle
op_last  out  1  final OP-stage cycle
busy  out  1  transaction in flight
resp_valid  out  1  result packed and available
resp_ready  in  1  consumer takes result
error  out  1  illegal command or normalize timeout; valid with resp_valid

Behaviour:
- Stage codes: unpack 0000, pack 0001, align 0010, normalize 0011, sum 0100, sub 0101, mul 0110, div 1000. IDLE and DONE drive 1111.
- Reset (rst_n low, asynchronous): state IDLE, stage 1111, stage_en 0, op_last 0, busy 0, resp_valid 0, error 0, req_ready 0. req_ready is a registered output and rises on the first clk edge after release.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_command, clear error, go UNPACK.
- Illegal command: go straight to DONE with error=1. No stage_en pulses are issued.
- UNPACK: 1 cycle. Next state is ALIGN for sum/sub, OP for mul/div.
- ALIGN: stage_en=1 every cycle. Leave to OP when align_done=1 is sampled, or after mant_bits+2 cycles. The limit case is not an error (operand fully shifted out).
- OP: stage code = latched op. Runs 1 cycle for sum/sub, mul_cycles for mul, div_cycles for div. op_last=1 on the final cycle only. Then NORMALIZE.
- NORMALIZE: stage_en=1 every cycle. Leave to PACK on norm_done=1. On reaching mant_bits+2 cycles without norm_done, set error=1 and go to PACK anyway.
- PACK: 1 cycle, then DONE.
- DONE: resp_valid=1, held stable with error until resp_ready=1, then IDLE. req_ready stays 0 in DONE, so the earliest next accept is the cycle after the handshake (no back-to-back).
- busy=1 in every state except IDLE. stage_en=0 in IDLE/DONE and 1 in all other states.
- Status-flag rule: align_done/norm_done are sampled only in their own stage. A flag already high on the first cycle of that stage gives a 1-cycle stage.
- Iteration counter: sized clog2(max(div_cycles, mant_bits+2)+1). Reset to 0 on every stage entry.
- Reset mid-operation aborts immediately to the reset state. No resp_valid is produced for the aborted request.
- req_command changes while not IDLE are ignored.

Test Plan:
- Sum, align_done and norm_done tied 1, accept at edge 0 -> stage 0000,0010,0100,0011,0001 in cycles 1-5, stage_en=1 in cycles 1-5, resp_valid=1 from cycle 6, error=0.
- Mul, mul_cycles=4, norm_done=1 -> stage 0110 for 4 cycles with op_last only on the 4th, resp_valid at cycle 8. Div with div_cycles=53 -> resp_valid at cycle 57.
- Sub, align_done asserted after 3 align cycles; norm_done never asserted -> normalize lasts 55 cycles, then pack, resp_valid with error=1.
- Command 5 -> DONE next cycle, resp_valid=1, error=1, no stage_en pulses. Next legal request clears error.
- resp_ready held 0 for 10 cycles -> resp_valid and error stable, req_ready=0. Raise resp_ready together with req_valid -> request accepted only one cycle after return to IDLE.
- rst_n pulsed low during div OP cycle 20 -> all outputs at reset values immediately. req_ready=1 one edge after release, and no stale resp_valid appears.

Source files
------------

// File: rtl/fpu_sequencer_if.sv
// Request/response handshake bundle for the FPU control sequencer.
// master: requester side; slave: sequencer side (req/resp valid-ready, error).
interface fpu_sequencer_if #(
  parameter int command_size = 2
);
  logic                  req_valid;
  logic                  req_ready;
  logic [command_size:0] req_command;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  error;

  modport master (
    output req_valid, req_command, resp_ready,
    input  req_ready, resp_valid, error
  );

  modport slave (
    input  req_valid, req_command, resp_ready,
    output req_ready, resp_valid, error
  );
endinterface

// File: rtl/fpu_sequencer.sv
// FPU control sequencer: unpack, align, op, normalize, pack stage stepping.
// Ports: clk, rst_n, bus (req/resp handshake), align_done, norm_done, stage/stage_en/op_last/busy.
module fpu_sequencer #(
  parameter int bitness      = 64,
  parameter int command_size = 2,
  parameter int mul_cycles   = 4,
  parameter int div_cycles   = 53,
  parameter int mant_bits    = 53
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpu_sequencer_if.slave       bus,
  input  logic                 align_done,
  input  logic                 norm_done,
  output logic [3:0]           stage,
  output logic                 stage_en,
  output logic                 op_last,
  output logic                 busy
);

  // Shifting past the operand width cannot change anything further.
  localparam int LIM  = (mant_bits + 2 < bitness + 1) ?
                        mant_bits + 2 : bitness + 1;
  localparam int M0   = (div_cycles > mul_cycles) ?
                        div_cycles : mul_cycles;
  localparam int MAXC = (M0 > mant_bits + 2) ? M0 : mant_bits + 2;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_OP, S_NORM, S_PACK, S_DONE
  } state_t;

  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   op_max;
  logic [1:0]      op;
  logic            err, err_n;
  logic            rdy;
  logic            accept;
  logic            legal;
  logic [3:0]      op_code;

  assign accept = (state == S_IDLE) && bus.req_valid && rdy;
  assign legal  = int'(bus.req_command) < 4;

  assign bus.req_ready = rdy;
  assign bus.error     = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op    <= '0;
      err   <= 1'b0;
      rdy   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? '0 : cnt + 1'b1;
      if (accept) op <= bus.req_command[1:0];
      err   <= err_n;
      rdy   <= (nxt == S_IDLE);
    end
  end

  always_comb begin
    op_max  = '0;
    op_code = 4'b0100;
    unique case (op)
      2'd0: op_code = 4'b0100;
      2'd1: op_code = 4'b0101;
      2'd2: begin
        op_code = 4'b0110;
        op_max  = CW'(mul_cycles - 1);
      end
      2'd3: begin
        op_code = 4'b1000;
        op_max  = CW'(div_cycles - 1);
      end
      default: op_code = 4'b0100;
    endcase
  end

  always_comb begin
    nxt            = state;
    err_n          = err;
    stage          = 4'b1111;
    stage_en       = 1'b0;
    op_last        = 1'b0;
    busy           = 1'b1;
    bus.resp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) begin
          err_n = !legal;
          nxt   = legal ? S_UNPACK : S_DONE;
        end
      end
      S_UNPACK: begin
        stage    = 4'b0000;
        stage_en = 1'b1;
        nxt      = op[1] ? S_OP : S_ALIGN;
      end
      S_ALIGN: begin
        stage    = 4'b0010;
        stage_en = 1'b1;
        if (align_done || cnt == CW'(LIM - 1)) nxt = S_OP;
      end
      S_OP: begin
        stage    = op_code;
        stage_en = 1'b1;
        if (cnt == op_max) begin
          op_last = 1'b1;
          nxt     = S_NORM;
        end
      end
      S_NORM: begin
        stage    = 4'b0011;
        stage_en = 1'b1;
        if (norm_done) begin
          nxt = S_PACK;
        end else if (cnt == CW'(LIM - 1)) begin
          err_n = 1'b1;
          nxt   = S_PACK;
        end
      end
      S_PACK: begin
        stage    = 4'b0001;
        stage_en = 1'b1;
        nxt      = S_DONE;
      end
      S_DONE: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer: scoreboard of error flag and latency.
// Latency n means resp_valid first seen in cycle n after the accept edge.
module tb_fpu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       align_done;
  logic       norm_done;
  logic [3:0] stage;
  logic       stage_en;
  logic       op_last;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic err;
    int   lat;
    time  t;
  } exp_t;

  exp_t q[$];
  logic seen;

  fpu_sequencer_if #(.command_size(2)) bus ();

  fpu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .align_done (align_done),
    .norm_done  (norm_done),
    .stage      (stage),
    .stage_en   (stage_en),
    .op_last    (op_last),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      seen <= 1'b0;
    end else if (bus.resp_valid && !seen) begin
      seen <= 1'b1;
      if (q.size() == 0) begin
        check("spurious_resp", 1, 0);
      end else begin
        exp_t e;
        int   lat;
        e   = q.pop_front();
        lat = int'(($time - e.t + 5) / 10);
        check("resp_latency", lat, e.lat);
        check("resp_error", bus.error, e.err);
      end
    end else if (!bus.resp_valid) begin
      seen <= 1'b0;
    end
  end

  task automatic send(input logic [2:0] cmd,
                      input logic err, input int lat);
    int   k;
    exp_t e;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.req_ready && k < 200);
    if (!bus.req_ready) check("req_ready_timeout", 0, 1);
    bus.req_valid   = 1'b1;
    bus.req_command = cmd;
    @(posedge clk);
    e.err = err;
    e.lat = lat;
    e.t   = $time;
    q.push_back(e);
    #1;
    bus.req_valid = 1'b0;
  endtask

  logic [3:0] sum_stg [1:5];

  initial begin
    exp_t e;
    int   k;
    sum_stg[1] = 4'b0000;
    sum_stg[2] = 4'b0010;
    sum_stg[3] = 4'b0100;
    sum_stg[4] = 4'b0011;
    sum_stg[5] = 4'b0001;
    rst_n           = 1'b0;
    seen            = 1'b0;
    align_done      = 1'b1;
    norm_done       = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_command = '0;
    bus.resp_ready  = 1'b1;
    #1;
    check("rst_stage", stage, 4'b1111);
    check("rst_busy", busy, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready_low", bus.req_ready, 0);
    @(posedge clk);
    #1;
    check("rel_req_ready_high", bus.req_ready, 1);

    // sum with flags tied high
    send(3'd0, 1'b0, 6);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check($sformatf("sum_stage_c%0d", n), stage, sum_stg[n]);
      check($sformatf("sum_en_c%0d", n), stage_en, 1);
    end

    // mul: op_last only on the 4th OP cycle
    send(3'd2, 1'b0, 8);
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n >= 2 && n <= 5)
        check($sformatf("mul_stage_c%0d", n), stage, 4'b0110);
      check($sformatf("mul_last_c%0d", n), op_last, n == 5);
    end

    // div full length
    send(3'd3, 1'b0, 57);
    repeat (60) @(negedge clk);

    // sub: align after 3 cycles, normalize timeout
    align_done = 1'b0;
    norm_done  = 1'b0;
    send(3'd1, 1'b1, 62);
    repeat (4) @(negedge clk);
    align_done = 1'b1;
    @(negedge clk);
    check("sub_op_stage", stage, 4'b0101);
    repeat (55) begin
      @(negedge clk);
      check("sub_norm_stage", stage, 4'b0011);
    end
    @(negedge clk);
    check("sub_pack_stage", stage, 4'b0001);
    repeat (3) @(negedge clk);
    norm_done = 1'b1;

    // illegal command, then a legal one clears error
    send(3'd5, 1'b1, 1);
    @(negedge clk);
    check("ill_stage_en", stage_en, 0);
    check("ill_resp_valid", bus.resp_valid, 1);
    send(3'd0, 1'b0, 6);
    repeat (8) @(negedge clk);

    // backpressure
    bus.resp_ready = 1'b0;
    send(3'd7, 1'b1, 1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bp_resp_valid", bus.resp_valid, 1);
      check("bp_error", bus.error, 1);
      check("bp_req_ready", bus.req_ready, 0);
    end
    bus.resp_ready  = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_command = 3'd0;
    @(negedge clk);
    check("bp_idle_busy", busy, 0);
    check("bp_idle_ready", bus.req_ready, 1);
    check("bp_idle_resp", bus.resp_valid, 0);
    @(posedge clk);
    e.err = 1'b0;
    e.lat = 6;
    e.t   = $time;
    q.push_back(e);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("bp_accept_stage", stage, 4'b0000);
    check("bp_accept_busy", busy, 1);
    repeat (8) @(negedge clk);

    // reset during div OP cycle 20
    send(3'd3, 1'b0, 57);
    repeat (21) @(negedge clk);
    check("pre_rst_stage", stage, 4'b1000);
    rst_n = 1'b0;
    #1;
    void'(q.pop_back());
    check("abort_stage", stage, 4'b1111);
    check("abort_en", stage_en, 0);
    check("abort_last", op_last, 0);
    check("abort_busy", busy, 0);
    check("abort_resp", bus.resp_valid, 0);
    check("abort_error", bus.error, 0);
    check("abort_ready", bus.req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_rel_ready", bus.req_ready, 1);
    repeat (70) @(negedge clk);
    check("abort_no_resp", bus.resp_valid, 0);

    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
